// File: rtl/parity_rx_check.sv
// Serial-to-parallel receiver for MSB-first frames of WIDTH data bits plus one
// parity bit; rebuilds the word, counts its ones and flags a parity mismatch.
module parity_rx_check #(
   parameter int WIDTH      = 8,
   parameter int ODD_PARITY = 0
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       start,
   input  logic                       serialin,
   input  logic                       bit_valid,
   output logic [WIDTH-1:0]           dataout,
   output logic [$clog2(WIDTH+1)-1:0] ones_count,
   output logic                       parity_rx,
   output logic                       parity_err,
   output logic                       busy,
   output logic                       done
);

   localparam int   CW      = $clog2(WIDTH + 1);
   localparam logic ODD_BIT = (ODD_PARITY != 0);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DATA = 2'd1,
      PAR  = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t           state_r, state_s;
   logic [WIDTH-1:0] data_r, data_s;
   logic [CW-1:0]    ones_r, ones_s;
   logic [CW-1:0]    cnt_r, cnt_s;
   logic             prx_r, prx_s;
   logic             perr_r, perr_s;
   logic             busy_r, busy_s;
   logic             done_r, done_s;

   function automatic logic even_parity(input logic [WIDTH-1:0] word);
      return ^word;
   endfunction

   // Next-state and next-field decode; start wins over any bit in the same cycle.
   always_comb begin
      state_s = state_r;
      data_s  = data_r;
      ones_s  = ones_r;
      cnt_s   = cnt_r;
      prx_s   = prx_r;
      perr_s  = perr_r;
      if (start) begin
         state_s = DATA;
         data_s  = {WIDTH{1'b0}};
         ones_s  = {CW{1'b0}};
         cnt_s   = {CW{1'b0}};
         prx_s   = 1'b0;
         perr_s  = 1'b0;
      end else begin
         case (state_r)
            IDLE: state_s = IDLE;
            DATA: begin
               if (bit_valid) begin
                  data_s = {data_r[WIDTH-2:0], serialin};
                  ones_s = ones_r + {{(CW-1){1'b0}}, serialin};
                  if (cnt_r == CW'(WIDTH - 1)) begin
                     cnt_s   = CW'(WIDTH);
                     state_s = PAR;
                  end else begin
                     cnt_s   = cnt_r + {{(CW-1){1'b0}}, 1'b1};
                     state_s = DATA;
                  end
               end else begin
                  state_s = DATA;
               end
            end
            PAR: begin
               if (bit_valid) begin
                  prx_s   = serialin;
                  perr_s  = serialin ^ even_parity(data_r) ^ ODD_BIT;
                  state_s = DONE;
               end else begin
                  state_s = PAR;
               end
            end
            DONE: state_s = DONE;
            default: state_s = IDLE;
         endcase
      end
      busy_s = (state_s == DATA) || (state_s == PAR);
      done_s = (state_s == DONE);
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_r <= IDLE;
         data_r  <= {WIDTH{1'b0}};
         ones_r  <= {CW{1'b0}};
         cnt_r   <= {CW{1'b0}};
         prx_r   <= 1'b0;
         perr_r  <= 1'b0;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         state_r <= state_s;
         data_r  <= data_s;
         ones_r  <= ones_s;
         cnt_r   <= cnt_s;
         prx_r   <= prx_s;
         perr_r  <= perr_s;
         busy_r  <= busy_s;
         done_r  <= done_s;
      end
   end

   assign dataout    = data_r;
   assign ones_count = ones_r;
   assign parity_rx  = prx_r;
   assign parity_err = perr_r;
   assign busy       = busy_r;
   assign done       = done_r;

endmodule

// File: tb/tb_parity_rx_check.sv
// Self-checking bench for parity_rx_check: frame vector table, corner-case
// sequences and random stimulus against a bit-queue reference model.
module tb_parity_rx_check;

   localparam int W = 8;

   logic clock = 1'b0;
   logic reset, start, serialin, bit_valid;
   logic [W-1:0] e_data, o_data;
   logic [3:0]   e_ones, o_ones;
   logic         e_prx, o_prx, e_perr, o_perr, e_busy, o_busy, e_done, o_done;

   int checks = 0;
   int errors = 0;

   // Reference model: bits accepted since the last start, plus frame flags.
   bit m_active = 1'b0;
   bit m_done   = 1'b0;
   bit m_bits[$];

   typedef struct {
      logic [7:0] data;
      logic       par;
      logic [3:0] exp_ones;
      logic       exp_err_even;
      logic       exp_err_odd;
   } vec_t;
   vec_t vecs[7];

   always #5 clock = ~clock;

   parity_rx_check #(.WIDTH(W), .ODD_PARITY(0)) dut_even (
      .clock(clock), .reset(reset), .start(start), .serialin(serialin),
      .bit_valid(bit_valid), .dataout(e_data), .ones_count(e_ones),
      .parity_rx(e_prx), .parity_err(e_perr), .busy(e_busy), .done(e_done));

   parity_rx_check #(.WIDTH(W), .ODD_PARITY(1)) dut_odd (
      .clock(clock), .reset(reset), .start(start), .serialin(serialin),
      .bit_valid(bit_valid), .dataout(o_data), .ones_count(o_ones),
      .parity_rx(o_prx), .parity_err(o_perr), .busy(o_busy), .done(o_done));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_update(input logic r, input logic s, input logic v, input logic b);
      if (r) begin
         m_active = 1'b0; m_done = 1'b0; m_bits.delete();
      end else if (s) begin
         m_active = 1'b1; m_done = 1'b0; m_bits.delete();
      end else if (m_active && v) begin
         m_bits.push_back(b);
         if (m_bits.size() == W + 1) begin
            m_active = 1'b0; m_done = 1'b1;
         end
      end
   endtask

   function automatic logic [15:0] model_out(input bit odd);
      logic [7:0] d = 8'h00;
      int n = m_bits.size();
      int k = (n > W) ? W : n;
      int ones;
      bit prx = 1'b0, perr = 1'b0;
      for (int i = 0; i < k; i++) d = (d * 8'd2) + {7'd0, m_bits[i]};
      ones = $countones(d);
      if (n > W) begin
         prx  = m_bits[W];
         perr = ((ones % 2) == 1) ^ prx ^ odd;
      end
      return {d, 4'(ones), prx, perr, m_active, m_done};
   endfunction

   task automatic check_all();
      check("even_dut_outputs", {16'h0, e_data, e_ones, e_prx, e_perr, e_busy, e_done},
            {16'h0, model_out(1'b0)});
      check("odd_dut_outputs", {16'h0, o_data, o_ones, o_prx, o_perr, o_busy, o_done},
            {16'h0, model_out(1'b1)});
   endtask

   task automatic step(input logic r, input logic s, input logic v, input logic b);
      reset = r; start = s; bit_valid = v; serialin = b;
      model_update(r, s, v, b);
      @(negedge clock);
      check_all();
   endtask

   task automatic send_frame(input logic [7:0] d, input logic p);
      step(1'b0, 1'b1, 1'b0, 1'b0);
      for (int i = 7; i >= 0; i--) step(1'b0, 1'b0, 1'b1, d[i]);
      step(1'b0, 1'b0, 1'b1, p);
   endtask

   initial begin
      vecs[0] = '{8'hA5, 1'b0, 4'd4, 1'b0, 1'b1};
      vecs[1] = '{8'h07, 1'b0, 4'd3, 1'b1, 1'b0};
      vecs[2] = '{8'hA5, 1'b1, 4'd4, 1'b1, 1'b0};
      vecs[3] = '{8'h00, 1'b0, 4'd0, 1'b0, 1'b1};
      vecs[4] = '{8'hFF, 1'b0, 4'd8, 1'b0, 1'b1};
      vecs[5] = '{8'h3C, 1'b0, 4'd4, 1'b0, 1'b1};
      vecs[6] = '{8'h80, 1'b1, 4'd1, 1'b0, 1'b1};

      reset = 1'b1; start = 1'b0; bit_valid = 1'b0; serialin = 1'b0;
      @(negedge clock);
      step(1'b1, 1'b0, 1'b0, 1'b0);
      check("reset_state", {e_data, e_ones, e_prx, e_perr, e_busy, e_done}, 16'h0000);

      // Latency of an unstalled 8'hA5 frame: done appears right after the parity bit.
      step(1'b0, 1'b1, 1'b0, 1'b0);
      check("busy_after_start", {30'd0, e_busy, e_done}, 32'd2);
      for (int i = 7; i >= 0; i--) step(1'b0, 1'b0, 1'b1, vecs[0].data[i]);
      check("no_done_before_parity", {31'd0, e_done}, 32'd0);
      step(1'b0, 1'b0, 1'b1, 1'b0);
      check("done_cycle10", {30'd0, e_busy, e_done}, 32'd1);
      check("a5_dataout", {24'd0, e_data}, 32'h0000_00A5);

      for (int t = 0; t < 7; t++) begin
         send_frame(vecs[t].data, vecs[t].par);
         check("vec_dataout", {24'd0, e_data}, {24'd0, vecs[t].data});
         check("vec_ones", {28'd0, e_ones}, {28'd0, vecs[t].exp_ones});
         check("vec_parity_rx", {31'd0, e_prx}, {31'd0, vecs[t].par});
         check("vec_err_even", {31'd0, e_perr}, {31'd0, vecs[t].exp_err_even});
         check("vec_err_odd", {31'd0, o_perr}, {31'd0, vecs[t].exp_err_odd});
         check("vec_done", {30'd0, e_busy, e_done}, 32'd1);
         for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 1'b1, 1'b1);
         check("done_holds", {24'd0, e_data}, {24'd0, vecs[t].data});
      end

      // Stalled 8'h00 frame, bit_valid toggling.
      step(1'b0, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 9; i++) begin
         if (i == 8) check("stall_no_early_done", {31'd0, e_done}, 32'd0);
         step(1'b0, 1'b0, 1'b1, 1'b0);
         step(1'b0, 1'b0, 1'b0, 1'b1);
      end
      check("stall_zero_frame", {e_data, e_ones, e_prx, e_perr, e_busy, e_done}, 16'h0001);

      // Abort after 4 bits of 8'hFF, then full 8'h3C frame.
      step(1'b0, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 1'b1);
      send_frame(8'h3C, 1'b0);
      check("abort_dataout", {24'd0, e_data}, 32'h0000_003C);
      check("abort_ones", {28'd0, e_ones}, 32'd4);
      check("abort_err", {31'd0, e_perr}, 32'd0);

      // Reset in mid-frame, then bit_valid without start.
      step(1'b0, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, 1'b1);
      step(1'b1, 1'b0, 1'b1, 1'b1);
      check("midframe_reset", {e_data, e_ones, e_prx, e_perr, e_busy, e_done}, 16'h0000);
      for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b1, 1'b1);
      check("idle_ignores_bits", {e_data, e_ones, e_prx, e_perr, e_busy, e_done}, 16'h0000);

      // Start coinciding with bit_valid discards that bit.
      step(1'b0, 1'b1, 1'b1, 1'b1);
      check("start_bit_discarded", {24'd0, e_data}, 32'd0);

      for (int c = 0; c < 4000; c++) begin
         step(($urandom_range(0, 149) == 0) ? 1'b1 : 1'b0,
              ($urandom_range(0, 39) == 0) ? 1'b1 : 1'b0,
              1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
